// File: rtl/sad_disparity_scheduler.sv
// rtl/sad_disparity_scheduler.sv - disparity search sequencer around a single-window SAD
module sad_disparity_scheduler #(
    parameter int WIN       = 15,
    parameter int DATA_SIZE = 8,
    parameter int MAX_DISP  = 3,
    parameter int DISP_W    = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1,
    parameter int SAD_W     = DATA_SIZE + $clog2(WIN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_SIZE*WIN-1:0] in_left,
    output logic                     fetch_req,
    output logic [DISP_W-1:0]        fetch_disp,
    input  logic                     fetch_ack,
    input  logic [DATA_SIZE*WIN-1:0] fetch_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DISP_W-1:0]        out_disp,
    output logic [SAD_W-1:0]         out_sad
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    localparam logic [DISP_W-1:0] LAST_DISP = DISP_W'(MAX_DISP - 1);

    state_t                   state_q, state_d;
    logic [DATA_SIZE*WIN-1:0] left_q, left_d;
    logic [DISP_W-1:0]        d_q, d_d;
    logic [DISP_W-1:0]        best_q, best_d;
    logic [SAD_W-1:0]         min_q, min_d;

    logic [DATA_SIZE-1:0]     diff [WIN];
    logic [SAD_W-1:0]         sad;

    // Per-pixel absolute difference between the captured left window and the fetched right window
    for (genvar g = 0; g < WIN; g++) begin : g_absdiff
        logic [DATA_SIZE-1:0] l_px;
        logic [DATA_SIZE-1:0] r_px;
        assign l_px    = left_q[g*DATA_SIZE +: DATA_SIZE];
        assign r_px    = fetch_data[g*DATA_SIZE +: DATA_SIZE];
        assign diff[g] = (l_px >= r_px) ? (l_px - r_px) : (r_px - l_px);
    end

    // Sum of absolute differences; SAD_W is wide enough that this never wraps
    always_comb begin
        sad = '0;
        for (int i = 0; i < WIN; i++) begin
            sad = sad + SAD_W'(diff[i]);
        end
    end

    // State and search registers; reset discards any in-flight search
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            left_q  <= '0;
            d_q     <= '0;
            best_q  <= '0;
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            d_q     <= d_d;
            best_q  <= best_d;
            min_q   <= min_d;
        end
    end

    // Next-state: capture window, walk disparities on each ack, hold result until consumed
    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        d_d     = d_q;
        best_d  = best_q;
        min_d   = min_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    left_d  = in_left;
                    d_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_ack) begin
                    // First candidate seeds the minimum; later ones must be strictly better,
                    // so ties stay with the lowest disparity.
                    if ((d_q == '0) || (sad < min_q)) begin
                        min_d  = sad;
                        best_d = d_q;
                    end
                    if (d_q == LAST_DISP) begin
                        state_d = S_DONE;
                    end else begin
                        d_d = d_q + DISP_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign fetch_req  = (state_q == S_FETCH);
    assign fetch_disp = (state_q == S_FETCH) ? d_q : '0;
    assign out_valid  = (state_q == S_DONE);
    assign out_disp   = best_q;
    assign out_sad    = min_q;

endmodule

// File: tb/tb_sad_disparity_scheduler.sv
// tb/tb_sad_disparity_scheduler.sv - scoreboard bench for sad_disparity_scheduler
module tb_sad_disparity_scheduler;

    localparam int WIN   = 15;
    localparam int DS    = 8;
    localparam int MD    = 3;
    localparam int DW    = 2;
    localparam int SW    = 12;
    localparam int WBITS = WIN * DS;

    typedef logic [WBITS-1:0] win_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    win_t          in_left;
    logic          fetch_req;
    logic [DW-1:0] fetch_disp;
    logic          fetch_ack;
    win_t          fetch_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_disp;
    logic [SW-1:0] out_sad;

    sad_disparity_scheduler #(
        .WIN(WIN), .DATA_SIZE(DS), .MAX_DISP(MD), .DISP_W(DW), .SAD_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left),
        .fetch_req(fetch_req), .fetch_disp(fetch_disp),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_disp(out_disp), .out_sad(out_sad)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   exp_disp_q[$];
    int   exp_sad_q[$];
    win_t rw_q[$];
    int   dly_q[$];
    win_t rset[MD];
    int   dset[MD];
    bit   hold_low   = 1'b0;
    bit   rand_ready = 1'b0;
    bit   lat_chk    = 1'b0;
    int   cyc        = 0;
    int   acc_cyc    = 0;
    bit   waiting    = 1'b0;
    int   cur_disp   = 0;
    int   wait_left  = 0;
    int   exp_d      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sad_of(input win_t l, input win_t r);
        int s;
        int a;
        int b;
        s = 0;
        for (int i = 0; i < WIN; i++) begin
            a = int'(l[i*DS +: DS]);
            b = int'(r[i*DS +: DS]);
            s += (a > b) ? (a - b) : (b - a);
        end
        return s;
    endfunction

    function automatic win_t ramp(input bit up);
        win_t w;
        for (int i = 0; i < WIN; i++) w[i*DS +: DS] = up ? DS'(i) : DS'(WIN - 1 - i);
        return w;
    endfunction

    function automatic win_t fill(input int v);
        win_t w;
        for (int i = 0; i < WIN; i++) w[i*DS +: DS] = DS'(v);
        return w;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int i = 0; i < WIN; i++) w[i*DS +: DS] = DS'($urandom_range(0, 255));
        return w;
    endfunction

    // Issue one window: the expected best is the lowest disparity of minimum SAD
    task automatic send(input win_t l);
        int best_d;
        int best_s;
        int s;
        int n;
        bit acc;
        best_d = 0;
        best_s = sad_of(l, rset[0]);
        for (int d = 1; d < MD; d++) begin
            s = sad_of(l, rset[d]);
            if (s < best_s) begin
                best_s = s;
                best_d = d;
            end
        end
        exp_disp_q.push_back(best_d);
        exp_sad_q.push_back(best_s);
        for (int d = 0; d < MD; d++) begin
            rw_q.push_back(rset[d]);
            dly_q.push_back(dset[d]);
        end
        in_left  = l;
        in_valid = 1'b1;
        n        = 0;
        acc      = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0;
        in_left  = rand_win();
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_disp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", exp_disp_q.size(), 0);
    endtask

    // Right-pixel buffer model: serves windows with programmed wait cycles
    initial begin
        fetch_ack  = 1'b0;
        fetch_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                fetch_ack = 1'b0;
            end else if (!fetch_req) begin
                fetch_ack  = 1'($urandom_range(0, 1));
                fetch_data = rand_win();
            end else begin
                if (!waiting) begin
                    waiting  = 1'b1;
                    cur_disp = int'(fetch_disp);
                    check("fetch_disp_order", int'(fetch_disp), exp_d);
                    wait_left = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
                end else begin
                    check("fetch_disp_hold", int'(fetch_disp), cur_disp);
                end
                if (wait_left == 0) begin
                    fetch_ack = 1'b1;
                    if (rw_q.size() > cur_disp) begin
                        fetch_data = rw_q[cur_disp];
                    end else begin
                        check("right_window_missing", 0, 1);
                        fetch_data = '0;
                    end
                    waiting = 1'b0;
                    exp_d++;
                    if (exp_d == MD) begin
                        exp_d = 0;
                        repeat (MD) if (rw_q.size() != 0) void'(rw_q.pop_front());
                    end
                end else begin
                    fetch_ack  = 1'b0;
                    fetch_data = rand_win();
                    wait_left--;
                end
            end
        end
    end

    // Consumer back-pressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: latency, result stability, and scoreboard comparison at each output handshake
    initial begin
        bit prev_ov;
        bit prev_hs;
        int prev_disp;
        int prev_sad;
        prev_ov   = 1'b0;
        prev_hs   = 1'b0;
        prev_disp = 0;
        prev_sad  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_ov = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_cyc = cyc;
                if (out_valid && !prev_ov && lat_chk) check("latency", cyc - acc_cyc, MD + 1);
                if (out_valid) check("in_ready_low_in_done", int'(in_ready), 0);
                if (out_valid && prev_ov && !prev_hs) begin
                    check("out_disp_stable", int'(out_disp), prev_disp);
                    check("out_sad_stable", int'(out_sad), prev_sad);
                end
                if (out_valid && out_ready) begin
                    if (exp_disp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        check("out_disp", int'(out_disp), exp_disp_q.pop_front());
                        check("out_sad", int'(out_sad), exp_sad_q.pop_front());
                    end
                end
                prev_ov   = out_valid;
                prev_hs   = out_valid && out_ready;
                prev_disp = int'(out_disp);
                prev_sad  = int'(out_sad);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached with %0d results pending", exp_disp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        win_t l;
        int   n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        for (int d = 0; d < MD; d++) dset[d] = 0;
        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_fetch_req", int'(fetch_req), 0);
        check("rst_fetch_disp", int'(fetch_disp), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_disp", int'(out_disp), 0);
        check("rst_out_sad", int'(out_sad), 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait directed windows with latency checking
        lat_chk = 1'b1;
        l       = ramp(1'b1);
        rset[0] = ramp(1'b1); rset[1] = ramp(1'b0); rset[2] = fill(0);
        send(l); drain();
        rset[0] = fill(255);
        send(l); drain();
        rset[0] = l; rset[1] = l; rset[2] = fill(0);
        send(l); drain();
        rset[0] = fill(0); rset[1] = fill(0); rset[2] = fill(0);
        send(fill(255)); drain();
        lat_chk = 1'b0;

        // Fetch wait states 0/3/1
        rset[0] = ramp(1'b1); rset[1] = ramp(1'b0); rset[2] = fill(0);
        dset[0] = 0; dset[1] = 3; dset[2] = 1;
        send(l); drain();
        for (int d = 0; d < MD; d++) dset[d] = 0;

        // Output back-pressure with a pending input
        hold_low = 1'b1;
        send(l);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_out_valid_seen", int'(out_valid), 1);
        @(posedge clk);
        #1;
        rset[0] = fill(0); rset[1] = ramp(1'b0); rset[2] = fill(7);
        fork
            send(ramp(1'b0));
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_in_ready", int'(in_ready), 0);
                end
                @(posedge clk);
                #1;
                hold_low = 1'b0;
            end
        join
        drain();

        // Asynchronous reset in the middle of a search
        rset[0] = ramp(1'b1); rset[1] = ramp(1'b0); rset[2] = fill(0);
        dset[1] = 3;
        send(l);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fetch_req && fetch_disp == DW'(1)) && n < 20);
        check("reset_point_reached", int'(fetch_req && fetch_disp == DW'(1)), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_fetch_req", int'(fetch_req), 0);
        check("async_in_ready", int'(in_ready), 1);
        check("async_out_valid", int'(out_valid), 0);
        check("async_fetch_disp", int'(fetch_disp), 0);
        check("async_out_sad", int'(out_sad), 0);
        exp_disp_q.delete();
        exp_sad_q.delete();
        rw_q.delete();
        dly_q.delete();
        waiting = 1'b0;
        exp_d   = 0;
        dset[1] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        rset[0] = fill(255); rset[1] = ramp(1'b0); rset[2] = fill(0);
        send(l); drain();
        lat_chk = 1'b0;

        // Randomized back-to-back traffic with ties, waits and back-pressure
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            l = rand_win();
            for (int d = 0; d < MD; d++) begin
                dset[d] = $urandom_range(0, 3);
                case ($urandom_range(0, 5))
                    0:       rset[d] = l;
                    1:       rset[d] = (d > 0) ? rset[d-1] : rand_win();
                    default: rset[d] = rand_win();
                endcase
            end
            send(l);
        end
        drain();
        rand_ready = 1'b0;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sad_disparity_scheduler.md
# sad_disparity_scheduler

Sequential controller that sequences the disparity search around the SAD datapath for one window. It captures a left window and requests the right-image window for each candidate disparity in turn from the right-pixel buffer. It computes the SAD of each candidate against the captured left window, tracks the minimum, and emits the best disparity and its SAD through a valid/ready handshake to the disparity-map writer.

## Interface
- `WIN`, 15, window width in pixels.
- `DATA_SIZE`, 8, bits per pixel.
- `MAX_DISP`, 3, number of candidate disparities (0..MAX_DISP-1); must be ≥1.
- `DISP_W`, $clog2(MAX_DISP) (minimum 1), disparity index width.
- `SAD_W`, DATA_SIZE+$clog2(WIN), SAD accumulator width; holds WIN·(2^DATA_SIZE−1) without overflow.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  left window offered.
- `in_ready`  out  1  block accepts a left window.
- `in_left`  in  DATA_SIZE·WIN  left window; pixel i at `[i*DATA_SIZE +: DATA_SIZE]`.
- `fetch_req`  out  1  request for the right window at `fetch_disp`.
- `fetch_disp`  out  DISP_W  candidate disparity being requested.
- `fetch_ack`  in  1  `fetch_data` valid for the current request.
- `fetch_data`  in  DATA_SIZE·WIN  right window; same packing as `in_left`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_disp`  out  DISP_W  disparity with minimum SAD.
- `out_sad`  out  SAD_W  SAD of that disparity.

## Operation
- States: IDLE, FETCH, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: register `in_left`, set d=0, and go to FETCH.
- FETCH:
  - `fetch_req`=1 and `fetch_disp`=d. Both are held stable until `fetch_ack`.
  - On the `fetch_ack` cycle, compute combinationally sad_d = Σ|left[i]−fetch_data[i]| at unsigned, SAD_W-wide precision.
  - For d=0, load min_sad=sad_0 and best=0 unconditionally.
  - For d>0, update only if sad_d < min_sad (strict). Ties keep the lower disparity.
  - If d==MAX_DISP−1, go to DONE and drop `fetch_req`. Otherwise increment d and stay in FETCH; `fetch_req` stays high with the new `fetch_disp` on the next cycle.
  - `fetch_ack` while `fetch_req`=0 is ignored.
- DONE:
  - `out_valid`=1. `out_disp` and `out_sad` are registered and stable until the handshake.
  - On `out_valid`&&`out_ready`, go to IDLE.
  - `in_ready`=0 while in FETCH or DONE, so there is exactly one window in flight.
- Reset (asynchronous, any state): go to IDLE immediately.
  - `in_ready`=1, `fetch_req`=0, `fetch_disp`=0, `out_valid`=0, `out_disp`=0, `out_sad`=0.
  - The in-flight search is discarded.
  - Any `fetch_ack` arriving in the first cycle after reset release is ignored.
- MAX_DISP=1: a single fetch, then DONE with `out_disp`=0.

## Timing
- `in_ready`, `fetch_req`, `fetch_disp` and `out_valid` are decoded from registered state only. There are no combinational paths from inputs to outputs.
- Zero-wait fetch (`fetch_ack` tied high):
  - Left window accepted at edge 0.
  - `fetch_req` high during cycles 1..MAX_DISP.
  - `out_valid` rises after edge MAX_DISP+1.
  - Latency is MAX_DISP+1 cycles from input handshake to `out_valid`.
- Each wait cycle on `fetch_ack` adds one cycle.
- Throughput with `out_ready`=1: one window per MAX_DISP+2 cycles. `in_ready` reasserts the cycle after the output handshake.
- `out_ready` low holds DONE indefinitely with outputs unchanged.

## Test plan
- Left=0..14; right d0=0..14, d1=14..0, d2=all 0; ack tied high → SADs 0/112/105; `out_disp`=0, `out_sad`=0. `out_valid` appears 4 cycles after input accept.
- Same left; d0=all 255, d1=14..0, d2=all 0 → SADs 3720/112/105; `out_disp`=2, `out_sad`=105.
- Tie: d0 and d1 both equal to left, d2=all 0 → `out_disp`=0, `out_sad`=0. Strict-less compare keeps the lowest disparity.
- Overflow bound: left all 255, every right window all 0 → `out_sad`=3825 (12 bits, no wrap), `out_disp`=0.
- Handshakes:
  - Delay `fetch_ack` by 0/3/1 cycles per disparity → `fetch_disp` stable while waiting, and the result matches the zero-wait case.
  - Hold `out_ready` low for 5 cycles → outputs stable, `in_ready`=0, and a pending `in_valid` is not accepted.
- Reset mid-op:
  - Assert `rst_n`=0 during d=1 → `fetch_req` drops without waiting for a clock edge; `in_ready`=1; `out_valid`=0.
  - A fresh search after release produces the correct result.
